// File: rtl/tlb_probe_read.sv
// TLBP/TLBR sequencer: scans the 16-entry TLB through a single read port for a
// VPN2/ASID match, or reads one entry into EntryHi/EntryLo0/EntryLo1.
// Optional feature: define TLB_PROBE_EARLY_EXIT_EN to end a probe on its first hit.
module tlb_probe_read (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid_i,
  output logic        op_ready_o,
  input  logic [1:0]  op_i,
  input  logic [31:0] index_i,
  input  logic [31:0] entryhi_i,
  output logic [3:0]  tlb_idx_o,
  input  logic [95:0] tlb_entry_i,
  output logic        done_o,
  output logic        index_we_o,
  output logic [31:0] index_o,
  output logic        entry_we_o,
  output logic [31:0] entryhi_o,
  output logic [31:0] entrylo0_o,
  output logic [31:0] entrylo1_o
);

  typedef enum logic [1:0] {IDLE, PROBE, READ, DONE} state_e;

  localparam logic [1:0] OpTlbp = 2'b01;
  localparam logic [1:0] OpTlbr = 2'b10;

  state_e      state_q, state_d;
  logic [1:0]  op_q;
  logic [18:0] vpn2_q;
  logic [7:0]  asid_q;
  logic [3:0]  ridx_q;
  logic [3:0]  cnt_q;
  logic        match_q;
  logic [3:0]  match_idx_q;
  logic [31:0] index_q, entryhi_q, lo0_q, lo1_q;

  logic accept, hit_now, last_scan;
  logic unused_bits;

  assign accept      = op_valid_i && (state_q == IDLE);
  assign hit_now     = (state_q == PROBE) && (tlb_entry_i[95:77] == vpn2_q)
                       && (tlb_entry_i[71:64] == asid_q);
  assign last_scan   = (cnt_q == 4'd15);
  assign unused_bits = ^{index_i[31:4], entryhi_i[12:8]};

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (op_i)
            OpTlbp:  state_d = PROBE;
            OpTlbr:  state_d = READ;
            default: state_d = DONE;
          endcase
        end
      end
      PROBE: begin
`ifdef TLB_PROBE_EARLY_EXIT_EN
        if (hit_now || last_scan) state_d = DONE;
`else
        if (last_scan) state_d = DONE;
`endif
      end
      READ:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    op_ready_o = (state_q == IDLE);
    done_o     = (state_q == DONE);
    index_we_o = (state_q == DONE) && (op_q == OpTlbp);
    entry_we_o = (state_q == DONE) && (op_q == OpTlbr);
    tlb_idx_o  = 4'd0;
    case (state_q)
      PROBE:   tlb_idx_o = cnt_q;
      READ:    tlb_idx_o = ridx_q;
      default: tlb_idx_o = 4'd0;
    endcase
  end

  assign index_o    = index_q;
  assign entryhi_o  = entryhi_q;
  assign entrylo0_o = lo0_q;
  assign entrylo1_o = lo1_q;

  // The earliest hit is kept; a hit on the final compare cycle is taken directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= 2'b00;
      vpn2_q      <= '0;
      asid_q      <= '0;
      ridx_q      <= '0;
      cnt_q       <= '0;
      match_q     <= 1'b0;
      match_idx_q <= '0;
      index_q     <= '0;
      entryhi_q   <= '0;
      lo0_q       <= '0;
      lo1_q       <= '0;
    end else begin
      if (accept) begin
        op_q    <= op_i;
        vpn2_q  <= entryhi_i[31:13];
        asid_q  <= entryhi_i[7:0];
        ridx_q  <= index_i[3:0];
        cnt_q   <= 4'd0;
        match_q <= 1'b0;
      end
      if (state_q == PROBE) begin
        if (!last_scan) cnt_q <= cnt_q + 4'd1;
        if (hit_now && !match_q) begin
          match_q     <= 1'b1;
          match_idx_q <= cnt_q;
        end
        if (state_d == DONE) begin
          if (match_q)      index_q <= {28'b0, match_idx_q};
          else if (hit_now) index_q <= {28'b0, cnt_q};
          else              index_q <= 32'h8000_0000;
        end
      end
      if (state_q == READ) begin
        entryhi_q <= tlb_entry_i[95:64];
        lo0_q     <= tlb_entry_i[63:32];
        lo1_q     <= tlb_entry_i[31:0];
      end
    end
  end

endmodule

// File: tb/tb_tlb_probe_read.sv
// Self-checking bench for tlb_probe_read: directed TLBP/TLBR/no-op/reset cases
// plus randomized operations against a lowest-index-wins TLB reference model.
module tb_tlb_probe_read;

  logic        clk = 1'b0;
  logic        rst;
  logic        opValid;
  logic        opReady;
  logic [1:0]  opCode;
  logic [31:0] indexIn;
  logic [31:0] entryHiIn;
  logic [3:0]  tlbIdx;
  logic [95:0] tlbEntry;
  logic        done;
  logic        indexWe;
  logic [31:0] indexOut;
  logic        entryWe;
  logic [31:0] entryHiOut, entryLo0Out, entryLo1Out;

  logic [95:0] tlb [16];
  logic [31:0] lastIndex, lastHi, lastLo0, lastLo1;
  int checks   = 0;
  int failures = 0;

  assign tlbEntry = tlb[tlbIdx];

  always #5 clk = ~clk;

  tlb_probe_read dut (
    .clk(clk), .rst(rst),
    .op_valid_i(opValid), .op_ready_o(opReady), .op_i(opCode),
    .index_i(indexIn), .entryhi_i(entryHiIn),
    .tlb_idx_o(tlbIdx), .tlb_entry_i(tlbEntry),
    .done_o(done), .index_we_o(indexWe), .index_o(indexOut),
    .entry_we_o(entryWe), .entryhi_o(entryHiOut),
    .entrylo0_o(entryLo0Out), .entrylo1_o(entryLo1Out)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [95:0] mkEntry(input logic [18:0] vpn2, input logic [7:0] asid,
                                          input logic [31:0] lo0, input logic [31:0] lo1);
    return {vpn2, 5'b0, asid, lo0, lo1};
  endfunction

  // Lowest-numbered entry whose VPN2 and ASID both match, or -1 on a miss.
  function automatic int probeModel(input logic [31:0] eh);
    for (int i = 0; i < 16; i++)
      if (tlb[i][95:77] == eh[31:13] && tlb[i][71:64] == eh[7:0]) return i;
    return -1;
  endfunction

  task automatic fillDefault();
    for (int i = 0; i < 16; i++)
      tlb[i] = mkEntry(19'h10000 + 19'(i), 8'hAA, 32'h1000 + 32'(i), 32'h2000 + 32'(i));
  endtask

  task automatic checkAllData(input string tag);
    checkOutput({tag, "_index"}, indexOut, lastIndex);
    checkOutput({tag, "_hi"}, entryHiOut, lastHi);
    checkOutput({tag, "_lo0"}, entryLo0Out, lastLo0);
    checkOutput({tag, "_lo1"}, entryLo1Out, lastLo1);
  endtask

  // Issue one operation and follow it to its done pulse; holdValid keeps the
  // request asserted (as a no-op) for the whole busy period.
  task automatic applyStimulus(input string tag, input logic [1:0] op,
                               input logic [31:0] idx, input logic [31:0] eh,
                               input bit holdValid);
    int hit, expLat, lat;
    bit seen;
    hit = probeModel(eh);
    case (op)
      2'b01: begin
`ifdef TLB_PROBE_EARLY_EXIT_EN
        expLat = (hit >= 0) ? hit + 2 : 17;
`else
        expLat = 17;
`endif
      end
      2'b10:   expLat = 2;
      default: expLat = 1;
    endcase
    @(negedge clk);
    opValid = 1'b1; opCode = op; indexIn = idx; entryHiIn = eh;
    checkOutput({tag, "_ready"}, 32'(opReady), 32'd1);
    @(posedge clk); #1;
    if (holdValid) opCode = 2'b11;
    else           opValid = 1'b0;
    seen = 0; lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1; lat = k;
        break;
      end
      checkOutput({tag, "_busy_ready"}, 32'(opReady), 32'd0);
      checkOutput({tag, "_busy_we"}, 32'({indexWe, entryWe}), 32'd0);
      checkOutput({tag, "_busy_idx"}, 32'(tlbIdx), (op == 2'b01) ? 32'(k - 1) : 32'(idx[3:0]));
    end
    checkOutput({tag, "_done_seen"}, 32'(seen), 32'd1);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
    if (op == 2'b01) lastIndex = (hit >= 0) ? 32'(hit) : 32'h8000_0000;
    if (op == 2'b10) begin
      lastHi  = tlb[idx[3:0]][95:64];
      lastLo0 = tlb[idx[3:0]][63:32];
      lastLo1 = tlb[idx[3:0]][31:0];
    end
    checkOutput({tag, "_index_we"}, 32'(indexWe), 32'(op == 2'b01));
    checkOutput({tag, "_entry_we"}, 32'(entryWe), 32'(op == 2'b10));
    checkOutput({tag, "_done_idx"}, 32'(tlbIdx), 32'd0);
    checkAllData(tag);
    @(negedge clk);
    checkOutput({tag, "_post_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_post_ready"}, 32'(opReady), 32'd1);
  endtask

  initial begin
    rst = 1'b1; opValid = 1'b0; opCode = 2'b00; indexIn = '0; entryHiIn = '0;
    fillDefault();
    lastIndex = '0; lastHi = '0; lastLo0 = '0; lastLo1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    checkOutput("reset_ready", 32'(opReady), 32'd1);
    checkOutput("reset_ctrl", 32'({done, indexWe, entryWe, tlbIdx}), 32'd0);
    checkAllData("reset");

    // Single hit at entry 5.
    tlb[5] = mkEntry(19'h00040, 8'h12, 32'h55, 32'h66);
    applyStimulus("tlbp_hit5", 2'b01, 32'd0, 32'h0008_0012, 0);
    checkOutput("tlbp_hit5_value", indexOut, 32'h0000_0005);

    // Duplicate matches at 3 and 9: lowest index wins.
    fillDefault();
    tlb[3] = mkEntry(19'h00040, 8'h12, 32'h33, 32'h34);
    tlb[9] = mkEntry(19'h00040, 8'h12, 32'h99, 32'h9A);
    applyStimulus("tlbp_dup", 2'b01, 32'd0, 32'h0008_0012, 0);
    checkOutput("tlbp_dup_value", indexOut, 32'h0000_0003);

    // ASID mismatch everywhere: miss with P bit.
    for (int i = 0; i < 16; i++) tlb[i] = mkEntry(19'h00040, 8'h13, 32'(i), 32'(i));
    applyStimulus("tlbp_miss", 2'b01, 32'd0, 32'h0008_0012, 0);
    checkOutput("tlbp_miss_value", indexOut, 32'h8000_0000);

    // TLBR of entry 15.
    fillDefault();
    tlb[15] = {32'h0008_0012, 32'h0000_0046, 32'h0000_0086};
    applyStimulus("tlbr_15", 2'b10, 32'h0000_000F, 32'd0, 0);
    checkOutput("tlbr_15_hi", entryHiOut, 32'h0008_0012);
    checkOutput("tlbr_15_lo0", entryLo0Out, 32'h0000_0046);
    checkOutput("tlbr_15_lo1", entryLo1Out, 32'h0000_0086);

    // Reset during the probe cycle that compares entry 8.
    @(negedge clk);
    opValid = 1'b1; opCode = 2'b01; entryHiIn = 32'h0008_0012;
    @(posedge clk); #1; opValid = 1'b0;
    repeat (9) @(negedge clk);
    checkOutput("rst_probe_idx", 32'(tlbIdx), 32'd8);
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    lastIndex = '0; lastHi = '0; lastLo0 = '0; lastLo1 = '0;
    @(negedge clk);
    checkOutput("rst_abort_ready", 32'(opReady), 32'd1);
    checkAllData("rst_abort");
    for (int k = 0; k < 20; k++) begin
      checkOutput("rst_abort_nodone", 32'({done, indexWe, entryWe}), 32'd0);
      @(negedge clk);
    end
    applyStimulus("tlbr_after_rst", 2'b10, 32'h0000_0007, 32'd0, 0);

    // Request held high while busy, then a trailing no-op.
    applyStimulus("hold_tlbr", 2'b10, 32'h0000_0002, 32'd0, 1);
    @(posedge clk); #1; opValid = 1'b0;
    @(negedge clk);
    checkOutput("hold_noop_done", 32'(done), 32'd1);
    checkOutput("hold_noop_we", 32'({indexWe, entryWe}), 32'd0);
    checkAllData("hold_noop");
    @(negedge clk);
    checkOutput("hold_noop_idle", 32'({done, opReady}), 32'b01);

    // Randomized operations over a TLB with frequent, often duplicated, matches.
    for (int n = 0; n < 24; n++) begin
      logic [1:0]  rop;
      logic [31:0] rIdx, rEh;
      for (int i = 0; i < 16; i++)
        tlb[i] = {19'($urandom_range(0, 3)), 5'($urandom), 8'($urandom_range(0, 1)),
                  32'($urandom), 32'($urandom)};
      rop  = 2'($urandom);
      rIdx = $urandom;
      rEh  = {19'($urandom_range(0, 3)), 5'($urandom), 8'($urandom_range(0, 1))};
      applyStimulus("random", rop, rIdx, rEh, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
